// File: rtl/dm_port_arbiter.sv
// rtl/dm_port_arbiter.sv - arbitrates the single-port data memory between the CPU MEM stage and a DMA master
// Sequences fixed-latency DM reads and stalls the pipeline while its access is outstanding.
module dm_port_arbiter #(
  parameter int ADDR_W     = 16,
  parameter int DATA_W     = 16,
  parameter int RD_LAT     = 1,
  parameter int STARVE_LIM = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_re,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_stall,
  input  logic              dma_req,
  input  logic              dma_we,
  input  logic [ADDR_W-1:0] dma_addr,
  input  logic [DATA_W-1:0] dma_wdata,
  output logic              dma_gnt,
  output logic              dma_rvalid,
  output logic [DATA_W-1:0] dma_rdata,
  output logic              mem_re,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int LAT_W = 3;
  localparam int SC_W  = $clog2(STARVE_LIM + 1);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RD_WAIT  = 2'd1,
    CPU_DONE = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic              owner_q, owner_d;
  logic [LAT_W-1:0]  lat_q, lat_d;
  logic [SC_W-1:0]   starve_q, starve_d;
  logic [DATA_W-1:0] cpu_rdata_q, cpu_rdata_d;
  logic [DATA_W-1:0] dma_rdata_q, dma_rdata_d;
  logic              dma_rvalid_q, dma_rvalid_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;

  logic can_issue;
  logic cpu_req;
  logic starved;
  logic dma_win;
  logic cpu_win;
  logic issue;
  logic issue_wr;
  logic stall_raw;

  // In CPU_DONE the held cpu_re belongs to the read just completed, so it is not a new request.
  assign can_issue = (state_q != RD_WAIT);
  assign cpu_req   = (state_q == IDLE) && (cpu_re || cpu_we);
  assign starved   = (starve_q == SC_W'(STARVE_LIM));
  assign dma_win   = can_issue && dma_req && (starved || !cpu_req);
  assign cpu_win   = cpu_req && !dma_win;
  assign issue     = cpu_win || dma_win;
  assign issue_wr  = cpu_win ? cpu_we : dma_we;

  always_comb begin
    stall_raw = 1'b0;
    case (state_q)
      IDLE:     stall_raw = cpu_req && !(cpu_win && cpu_we);
      RD_WAIT:  stall_raw = !owner_q || cpu_re || cpu_we;
      default:  stall_raw = 1'b0;
    endcase
  end

  assign cpu_stall  = stall_raw && !rst;
  assign dma_gnt    = dma_win && !rst;
  assign mem_we     = issue && issue_wr && !rst;
  assign mem_re     = issue && !issue_wr && !rst;
  assign mem_addr   = addr_d;
  assign mem_wdata  = wdata_d;
  assign cpu_rdata  = cpu_rdata_q;
  assign dma_rdata  = dma_rdata_q;
  assign dma_rvalid = dma_rvalid_q;

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    lat_d        = lat_q;
    starve_d     = starve_q;
    cpu_rdata_d  = cpu_rdata_q;
    dma_rdata_d  = dma_rdata_q;
    dma_rvalid_d = 1'b0;
    addr_d       = addr_q;
    wdata_d      = wdata_q;

    if (issue) begin
      addr_d  = cpu_win ? cpu_addr : dma_addr;
      wdata_d = cpu_win ? cpu_wdata : dma_wdata;
    end

    // Starvation only accrues on cycles where the DMA could have issued but lost.
    if (!dma_req || dma_win) begin
      starve_d = '0;
    end else if (can_issue && !starved) begin
      starve_d = starve_q + SC_W'(1);
    end

    case (state_q)
      RD_WAIT: begin
        if (lat_q == LAT_W'(RD_LAT)) begin
          if (owner_q) begin
            dma_rdata_d  = mem_rdata;
            dma_rvalid_d = 1'b1;
            state_d      = IDLE;
          end else begin
            cpu_rdata_d = mem_rdata;
            state_d     = CPU_DONE;
          end
        end else begin
          lat_d = lat_q + LAT_W'(1);
        end
      end
      IDLE, CPU_DONE: begin
        if (issue && !issue_wr) begin
          state_d = RD_WAIT;
          owner_d = dma_win;
          lat_d   = LAT_W'(1);
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      owner_q      <= 1'b0;
      lat_q        <= '0;
      starve_q     <= '0;
      cpu_rdata_q  <= '0;
      dma_rdata_q  <= '0;
      dma_rvalid_q <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      lat_q        <= lat_d;
      starve_q     <= starve_d;
      cpu_rdata_q  <= cpu_rdata_d;
      dma_rdata_q  <= dma_rdata_d;
      dma_rvalid_q <= dma_rvalid_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
    end
  end

endmodule
